// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side handshake and redirect bus between the PC generator and its neighbours.
// master = PC generator, slave = fetch unit / redirect source.
interface pc_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] pc;
    logic                  ce;
    logic                  if_ready;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;

    modport master (
        output pc,
        output ce,
        input  if_ready,
        input  redirect_valid,
        input  redirect_target
    );

    modport slave (
        input  pc,
        input  ce,
        output if_ready,
        output redirect_valid,
        output redirect_target
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// IF-stage program-counter generator: valid/ready fetch address, one-deep redirect
// buffer for stalls, halt/resume and misaligned-target reporting.
//
// state | meaning
// BOOT  | one cycle after reset, ce=0, pc=RESET_VECTOR
// RUN   | ce=1, pc offered to fetch, advances on fire
// HALT  | ce=0, redirects land directly on pc
module pc_fetch_ctrl #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    INST_BYTES   = 4,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_fetch_ctrl_if.master       fif,
    input  logic                  halt,
    output logic                  misalign_err,
    output logic [ADDR_WIDTH-1:0] misalign_addr,
    output logic [CNT_WIDTH-1:0]  fetch_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(INST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(INST_BYTES - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc_q, pc_nxt;
    logic                  pend_v, pend_v_nxt;
    logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_nxt;
    logic                  err_nxt;
    logic [ADDR_WIDTH-1:0] maddr_nxt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic                  aligned, rd_ok, rd_bad, fire;

    assign fif.ce = (state == RUN);
    assign fif.pc = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc_q          <= RESET_VECTOR;
            pend_v        <= 1'b0;
            pend_addr     <= '0;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
            fetch_cnt     <= '0;
        end else begin
            state         <= state_nxt;
            pc_q          <= pc_nxt;
            pend_v        <= pend_v_nxt;
            pend_addr     <= pend_addr_nxt;
            misalign_err  <= err_nxt;
            misalign_addr <= maddr_nxt;
            fetch_cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_q;
        pend_v_nxt    = pend_v;
        pend_addr_nxt = pend_addr;
        err_nxt       = 1'b0;
        maddr_nxt     = misalign_addr;
        cnt_nxt       = fetch_cnt;

        aligned = ((fif.redirect_target & OFF_MASK) == '0);
        rd_ok   = fif.redirect_valid && aligned;
        rd_bad  = fif.redirect_valid && !aligned;
        fire    = (state == RUN) && fif.if_ready;

        if (fire) begin
            cnt_nxt = fetch_cnt + CNT_WIDTH'(1);
        end

        case (state)
            BOOT: begin
                state_nxt = halt ? HALT : RUN;
            end
            RUN: begin
                if (fire) begin
                    if (rd_ok) begin
                        pc_nxt = fif.redirect_target;
                    end else if (pend_v) begin
                        pc_nxt = pend_addr;
                    end else begin
                        pc_nxt = pc_q + STEP;
                    end
                    pend_v_nxt = 1'b0;
                    if (halt) begin
                        state_nxt = HALT;
                    end
                end else if (rd_ok) begin
                    // newest redirect wins while the current fetch is stalled
                    pend_v_nxt    = 1'b1;
                    pend_addr_nxt = fif.redirect_target;
                end
            end
            HALT: begin
                if (rd_ok) begin
                    pc_nxt = fif.redirect_target;
                end else if (pend_v) begin
                    pc_nxt = pend_addr;
                end
                pend_v_nxt = 1'b0;
                if (!halt) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase

        if (rd_bad && (state != BOOT)) begin
            err_nxt   = 1'b1;
            maddr_nxt = fif.redirect_target;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, an INST_BYTES=2 alignment sequence,
// and randomized traffic against a behavioural model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hlt = 1'b0;
    logic hlt2 = 1'b0;
    logic        err, err2;
    logic [31:0] maddr, maddr2;
    logic [15:0] cnt, cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.ADDR_WIDTH(32)) fif ();
    pc_fetch_ctrl_if #(.ADDR_WIDTH(32)) fif2 ();

    pc_fetch_ctrl #(.ADDR_WIDTH(32), .RESET_VECTOR(RV), .INST_BYTES(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .fif(fif), .halt(hlt),
        .misalign_err(err), .misalign_addr(maddr), .fetch_cnt(cnt)
    );

    pc_fetch_ctrl #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .INST_BYTES(2), .CNT_WIDTH(16)) dut2 (
        .clk(clk), .rst(rst), .fif(fif2), .halt(hlt2),
        .misalign_err(err2), .misalign_addr(maddr2), .fetch_cnt(cnt2)
    );

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          hlt;
        bit          rv;
        logic [31:0] rt;
        bit          e_ce;
        logic [31:0] e_pc;
        logic [15:0] e_cnt;
        bit          e_err;
        logic [31:0] e_maddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, bit rd, bit h, bit rv_i, logic [31:0] rt_i,
                               bit ce_e, logic [31:0] pc_e, logic [15:0] cnt_e,
                               bit err_e, logic [31:0] ma_e);
        vec_t x;
        x.rst = r; x.rdy = rd; x.hlt = h; x.rv = rv_i; x.rt = rt_i;
        x.e_ce = ce_e; x.e_pc = pc_e; x.e_cnt = cnt_e; x.e_err = err_e; x.e_maddr = ma_e;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // behavioural reference: mode 0=boot 1=running 2=halted, pending redirect as a queue
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    int          m_cnt;
    bit          m_err;
    logic [31:0] m_maddr;

    task automatic ref_step(bit r, bit rd, bit h, bit rv_i, logic [31:0] rt_i);
        bit ok, bad, fire;
        if (r) begin
            m_mode = 0; m_pc = RV; m_pend.delete(); m_cnt = 0; m_err = 0; m_maddr = 0;
            return;
        end
        ok   = rv_i && (rt_i % 4 == 0);
        bad  = rv_i && (rt_i % 4 != 0);
        fire = (m_mode == 1) && rd;
        m_err = (m_mode != 0) && bad;
        if (m_err) m_maddr = rt_i;
        if (m_mode == 0) begin
            m_mode = h ? 2 : 1;
        end else if (m_mode == 1) begin
            if (fire) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (ok) m_pc = rt_i;
                else if (m_pend.size() > 0) m_pc = m_pend[0];
                else m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
                m_pend.delete();
                if (h) m_mode = 2;
            end else if (ok) begin
                m_pend.delete();
                m_pend.push_back(rt_i);
            end
        end else begin
            if (ok) m_pc = rt_i;
            if (!h) m_mode = 1;
        end
    endtask

    initial begin
        fif.if_ready = 1'b0; fif.redirect_valid = 1'b0; fif.redirect_target = '0;
        fif2.if_ready = 1'b0; fif2.redirect_valid = 1'b0; fif2.redirect_target = '0;

        //               rst rdy hlt rv target        ce pc            cnt err maddr
        tbl.push_back(v(1, 1, 0, 0, 32'h0,          0, RV,            0,  0, 32'h0));
        tbl.push_back(v(1, 1, 0, 0, 32'h0,          0, RV,            0,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, RV,            0,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h8000_0004, 1,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h8000_0008, 2,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h8000_000C, 3,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 1, 32'h40,         1, 32'h40,        4,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 1, 32'h1000,       1, 32'h1000,      5,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h1004,      6,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 1, 32'h100,        1, 32'h100,       7,  0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 32'h200,        1, 32'h100,       7,  0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 32'h300,        1, 32'h100,       7,  0, 32'h0));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,          1, 32'h100,       7,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h300,       8,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h304,       9,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 1, 32'h202,        1, 32'h308,       10, 1, 32'h202));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h30C,       11, 0, 32'h202));
        tbl.push_back(v(0, 0, 0, 1, 32'h400,        1, 32'h30C,       11, 0, 32'h202));
        tbl.push_back(v(0, 0, 0, 1, 32'h403,        1, 32'h30C,       11, 1, 32'h403));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h400,       12, 0, 32'h403));
        tbl.push_back(v(0, 1, 0, 1, 32'h500,        1, 32'h500,       13, 0, 32'h403));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,          1, 32'h500,       13, 0, 32'h403));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,          1, 32'h500,       13, 0, 32'h403));
        tbl.push_back(v(0, 1, 1, 0, 32'h0,          0, 32'h504,       14, 0, 32'h403));
        tbl.push_back(v(0, 1, 1, 1, 32'h600,        0, 32'h600,       14, 0, 32'h403));
        tbl.push_back(v(0, 1, 1, 0, 32'h0,          0, 32'h600,       14, 0, 32'h403));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h600,       14, 0, 32'h403));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h604,       15, 0, 32'h403));
        tbl.push_back(v(0, 1, 0, 1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, 16, 0, 32'h403));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h0,         17, 0, 32'h403));
        tbl.push_back(v(0, 0, 0, 1, 32'h700,        1, 32'h0,         17, 0, 32'h403));
        tbl.push_back(v(1, 0, 0, 0, 32'h0,          0, RV,            0,  0, 32'h0));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,          1, RV,            0,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h8000_0004, 1,  0, 32'h0));
        tbl.push_back(v(1, 0, 0, 0, 32'h0,          0, RV,            0,  0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 32'h0,          0, RV,            0,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, RV,            0,  0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h8000_0004, 1,  0, 32'h0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; hlt = tbl[i].hlt;
            fif.if_ready = tbl[i].rdy;
            fif.redirect_valid = tbl[i].rv;
            fif.redirect_target = tbl[i].rt;
            tick();
            check($sformatf("vec%0d.ce", i),    32'(fif.ce), 32'(tbl[i].e_ce));
            check($sformatf("vec%0d.pc", i),    fif.pc,      tbl[i].e_pc);
            check($sformatf("vec%0d.cnt", i),   32'(cnt),    32'(tbl[i].e_cnt));
            check($sformatf("vec%0d.err", i),   32'(err),    32'(tbl[i].e_err));
            check($sformatf("vec%0d.maddr", i), maddr,       tbl[i].e_maddr);
        end

        // INST_BYTES=2 instance: it has been sitting stalled at pc=0 in RUN
        fif.if_ready = 1'b0; fif.redirect_valid = 1'b0;
        fif2.if_ready = 1'b1; fif2.redirect_valid = 1'b1; fif2.redirect_target = 32'h202;
        tick();
        check("ib2.accept_pc", fif2.pc, 32'h202);
        check("ib2.accept_err", 32'(err2), 32'h0);
        fif2.redirect_target = 32'h203;
        tick();
        check("ib2.seq_pc", fif2.pc, 32'h204);
        check("ib2.reject_err", 32'(err2), 32'h1);
        check("ib2.reject_addr", maddr2, 32'h203);
        fif2.redirect_valid = 1'b0;
        tick();
        check("ib2.err_pulse", 32'(err2), 32'h0);
        check("ib2.seq_pc2", fif2.pc, 32'h206);
        fif2.if_ready = 1'b0;

        // randomized traffic against the reference model
        rst = 1'b1;
        ref_step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        for (int c = 0; c < 4000; c++) begin
            bit          r_r, r_rdy, r_h, r_rv;
            logic [31:0] r_t;
            r_r   = ($urandom_range(0, 99) == 0);
            r_rdy = ($urandom_range(0, 99) < 55);
            r_h   = ($urandom_range(0, 99) < ((c / 200) % 2 == 1 ? 60 : 10));
            r_rv  = ($urandom_range(0, 99) < 30);
            case ($urandom_range(0, 3))
                0: r_t = $urandom();
                1: r_t = 32'hFFFF_FFF0 | {$urandom_range(0, 3), 2'b00};
                default: r_t = {$urandom_range(0, 65535), 2'b00};
            endcase
            rst = r_r; hlt = r_h;
            fif.if_ready = r_rdy; fif.redirect_valid = r_rv; fif.redirect_target = r_t;
            ref_step(r_r, r_rdy, r_h, r_rv, r_t);
            tick();
            n_checks++;
            if (fif.pc !== m_pc || fif.ce !== (m_mode == 1) || cnt !== 16'(m_cnt) ||
                err !== m_err || maddr !== m_maddr) begin
                n_fail++;
                $display("FAIL rand%0d: pc=0x%08h ce=%0b cnt=%0d err=%0b maddr=0x%08h expected pc=0x%08h ce=%0b cnt=%0d err=%0b maddr=0x%08h",
                         c, fif.pc, fif.ce, cnt, err, maddr, m_pc, (m_mode == 1), m_cnt, m_err, m_maddr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
